// File: rtl/reg_file_sb.sv
// Register bank with two forwarding read ports, one write port and a
// per-register pending-write scoreboard for read-after-write hazard detection.
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] AR1,
  input  logic [ADDR_W-1:0] AR2,
  output logic [WIDTH-1:0]  DR1,
  output logic [WIDTH-1:0]  DR2,
  output logic              BUSY1,
  output logic              BUSY2,
  input  logic              REG_WRITE,
  input  logic [ADDR_W-1:0] AW,
  input  logic [WIDTH-1:0]  DIN,
  input  logic              RESERVE,
  input  logic [ADDR_W-1:0] ARES,
  output logic [ADDR_W:0]   PEND_CNT
);

  logic [WIDTH-1:0]  mem_reg [DEPTH];
  logic [DEPTH-1:0]  pending_reg;
  logic [DEPTH-1:0]  pending_next;
  logic [ADDR_W:0]   pend_cnt_reg;
  logic [ADDR_W:0]   pend_cnt_next;
  logic              write_en;
  logic              reserve_en;

  // Register 0 is hard-wired when ZERO_REG is set: writes and reserves to it are dropped.
  assign write_en   = REG_WRITE && !((ZERO_REG != 0) && (AW == '0));
  assign reserve_en = RESERVE && !((ZERO_REG != 0) && (ARES == '0));

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      // A reserve on the same edge as the releasing write keeps the bit set.
      assign pending_next[gi] = (reserve_en && (ARES == ADDR_W'(gi))) ||
                                (pending_reg[gi] && !(write_en && (AW == ADDR_W'(gi))));

      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          mem_reg[gi] <= '0;
        end else if (write_en && (AW == ADDR_W'(gi))) begin
          mem_reg[gi] <= DIN;
        end
      end
    end
  endgenerate

  always_comb begin
    pend_cnt_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_next = pend_cnt_next + (ADDR_W+1)'(pending_next[i]);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending_reg  <= '0;
      pend_cnt_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign PEND_CNT = pend_cnt_reg;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];
  logic              rd_busy [2];

  assign rd_addr[0] = AR1;
  assign rd_addr[1] = AR2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // Forwarding uses the raw REG_WRITE: a zero-register write is caught by the first branch.
      always_comb begin
        rd_data[gi] = mem_reg[rd_addr[gi]];
        rd_busy[gi] = pending_reg[rd_addr[gi]];
        if ((ZERO_REG != 0) && (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
          rd_busy[gi] = 1'b0;
        end else if (REG_WRITE && (AW == rd_addr[gi])) begin
          rd_data[gi] = DIN;
          rd_busy[gi] = 1'b0;
        end
      end
    end
  endgenerate

  assign DR1   = rd_data[0];
  assign DR2   = rd_data[1];
  assign BUSY1 = rd_busy[0];
  assign BUSY2 = rd_busy[1];

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: expectations are queued as stimulus is
// driven and compared against the DUT outputs sampled mid-cycle.
module tb_reg_file_sb;

  localparam int WIDTH  = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic [ADDR_W-1:0] AR1 = '0;
  logic [ADDR_W-1:0] AR2 = '0;
  logic [WIDTH-1:0]  DR1;
  logic [WIDTH-1:0]  DR2;
  logic              BUSY1;
  logic              BUSY2;
  logic              REG_WRITE = 1'b0;
  logic [ADDR_W-1:0] AW = '0;
  logic [WIDTH-1:0]  DIN = '0;
  logic              RESERVE = 1'b0;
  logic [ADDR_W-1:0] ARES = '0;
  logic [ADDR_W:0]   PEND_CNT;

  reg_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST), .AR1(AR1), .AR2(AR2), .DR1(DR1), .DR2(DR2),
    .BUSY1(BUSY1), .BUSY2(BUSY2), .REG_WRITE(REG_WRITE), .AW(AW), .DIN(DIN),
    .RESERVE(RESERVE), .ARES(ARES), .PEND_CNT(PEND_CNT)
  );

  always #5 CLK = ~CLK;

  int compare_cnt  = 0;
  int mismatch_cnt = 0;

  // Selectors for which output a queued expectation refers to.
  localparam int SEL_DR1 = 0, SEL_DR2 = 1, SEL_BUSY1 = 2, SEL_BUSY2 = 3, SEL_PEND = 4;

  string       tag_q [$];
  int          sel_q [$];
  logic [31:0] exp_q [$];

  logic [31:0] mem_m  [DEPTH];
  logic        pend_m [DEPTH];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_cnt++;
    if (obs !== exp) begin
      mismatch_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic sb_push(input string tag, input int sel, input logic [31:0] exp);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
    exp_q.push_back(exp);
  endtask

  task automatic sb_drain();
    string       t;
    int          s;
    logic [31:0] e;
    logic [31:0] obs;
    while (tag_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      case (s)
        SEL_DR1:   obs = DR1;
        SEL_DR2:   obs = DR2;
        SEL_BUSY1: obs = {31'd0, BUSY1};
        SEL_BUSY2: obs = {31'd0, BUSY2};
        default:   obs = {26'd0, PEND_CNT};
      endcase
      check_val(t, obs, e);
    end
  endtask

  function automatic logic [31:0] model_pend_cnt();
    logic [31:0] c = 0;
    for (int i = 0; i < DEPTH; i++) c += {31'd0, pend_m[i]};
    return c;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i]  = '0;
      pend_m[i] = 1'b0;
    end
  endtask

  // Expected read result for one port from the reference model.
  task automatic model_read(input logic [ADDR_W-1:0] ar, output logic [31:0] d, output logic b);
    if (ar == 0) begin
      d = '0; b = 1'b0;
    end else if (REG_WRITE && AW == ar) begin
      d = DIN; b = 1'b0;
    end else begin
      d = mem_m[ar]; b = pend_m[ar];
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue model expectations.
  task automatic drive(input logic we, input logic [ADDR_W-1:0] aw, input logic [31:0] din,
                       input logic res, input logic [ADDR_W-1:0] ares,
                       input logic [ADDR_W-1:0] ar1, input logic [ADDR_W-1:0] ar2,
                       input bit use_model);
    logic [31:0] d;
    logic        b;
    @(negedge CLK);
    REG_WRITE = we; AW = aw; DIN = din; RESERVE = res; ARES = ares; AR1 = ar1; AR2 = ar2;
    #1;
    if (use_model) begin
      model_read(ar1, d, b);
      sb_push("model_dr1", SEL_DR1, d);
      sb_push("model_busy1", SEL_BUSY1, {31'd0, b});
      model_read(ar2, d, b);
      sb_push("model_dr2", SEL_DR2, d);
      sb_push("model_busy2", SEL_BUSY2, {31'd0, b});
      sb_push("model_pend", SEL_PEND, model_pend_cnt());
    end
  endtask

  // Let the rising edge happen and advance the model the same way.
  task automatic commit();
    @(posedge CLK);
    if (REG_WRITE && AW != 0) begin
      mem_m[AW]  = DIN;
      pend_m[AW] = 1'b0;
    end
    if (RESERVE && ARES != 0) pend_m[ARES] = 1'b1;
  endtask

  task automatic step(input logic we, input logic [ADDR_W-1:0] aw, input logic [31:0] din,
                      input logic res, input logic [ADDR_W-1:0] ares,
                      input logic [ADDR_W-1:0] ar1, input logic [ADDR_W-1:0] ar2);
    drive(we, aw, din, res, ares, ar1, ar2, 1'b1);
    sb_drain();
    commit();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_clear();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Fill every register with random data and reserve a few, then read back.
    for (int a = 0; a < DEPTH; a++)
      step(1'b1, ADDR_W'(a), $urandom(), (a % 5) == 0, ADDR_W'((a * 7) % DEPTH), ADDR_W'(a), ADDR_W'(DEPTH - 1 - a));
    for (int a = 0; a < 4; a++)
      step(1'b0, '0, '0, 1'b0, '0, ADDR_W'(a + 4), ADDR_W'(a + 20));

    // Reset with live data: every address must read back as zero and idle.
    @(negedge CLK);
    RST = 1'b1;
    REG_WRITE = 1'b0; RESERVE = 1'b0;
    model_clear();
    for (int a = 0; a < DEPTH; a++) begin
      AR1 = ADDR_W'(a); AR2 = ADDR_W'(DEPTH - 1 - a);
      #1;
      sb_push("rst_dr1", SEL_DR1, 32'd0);
      sb_push("rst_dr2", SEL_DR2, 32'd0);
      sb_push("rst_busy1", SEL_BUSY1, 32'd0);
      sb_push("rst_busy2", SEL_BUSY2, 32'd0);
      sb_push("rst_pend", SEL_PEND, 32'd0);
      sb_drain();
    end
    @(negedge CLK);
    RST = 1'b0;

    // Write r7 with same-cycle forward on port 2, then read from storage.
    drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, '0, 5'd0, 5'd7, 1'b1);
    sb_push("fwd_dr2", SEL_DR2, 32'hDEADBEEF);
    sb_drain();
    commit();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd7, 5'd0, 1'b1);
    sb_push("stored_dr1", SEL_DR1, 32'hDEADBEEF);
    sb_drain();
    commit();

    // Zero register ignores both write and reserve.
    drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
    sb_push("zero_fwd_dr1", SEL_DR1, 32'd0);
    sb_drain();
    commit();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0, 1'b1);
    sb_push("zero_dr1", SEL_DR1, 32'd0);
    sb_push("zero_busy1", SEL_BUSY1, 32'd0);
    sb_push("zero_pend", SEL_PEND, 32'd0);
    sb_drain();
    commit();

    // Reserve r3: not busy in the reserve cycle, busy after, released by write.
    drive(1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1);
    sb_push("res_same_busy1", SEL_BUSY1, 32'd0);
    sb_drain();
    commit();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd0, 1'b1);
    sb_push("res_busy1", SEL_BUSY1, 32'd1);
    sb_push("res_pend", SEL_PEND, 32'd1);
    sb_drain();
    commit();
    drive(1'b1, 5'd3, 32'h55, 1'b0, '0, 5'd3, 5'd0, 1'b1);
    sb_push("rel_busy1", SEL_BUSY1, 32'd0);
    sb_push("rel_dr1", SEL_DR1, 32'h55);
    sb_drain();
    commit();
    drive(1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd0, 1'b1);
    sb_push("rel_pend", SEL_PEND, 32'd0);
    sb_drain();
    commit();

    // Reserve and write r9 on the same edge: data lands, reservation survives.
    step(1'b1, 5'd9, 32'hA5, 1'b1, 5'd9, 5'd9, 5'd3);
    drive(1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9, 1'b1);
    sb_push("both_dr1", SEL_DR1, 32'hA5);
    sb_push("both_busy1", SEL_BUSY1, 32'd1);
    sb_push("both_pend", SEL_PEND, 32'd1);
    sb_drain();
    commit();

    // Reserve r1..r31 (r9 already pending), then reset between edges.
    for (int a = 1; a < DEPTH; a++)
      step(1'b0, '0, '0, 1'b1, ADDR_W'(a), ADDR_W'(a), 5'd9);
    drive(1'b0, '0, '0, 1'b0, '0, 5'd1, 5'd31, 1'b1);
    sb_push("full_pend", SEL_PEND, 32'd31);
    sb_push("full_busy1", SEL_BUSY1, 32'd1);
    sb_drain();
    #1 RST = 1'b1;
    model_clear();
    #1;
    sb_push("async_pend", SEL_PEND, 32'd0);
    sb_push("async_busy1", SEL_BUSY1, 32'd0);
    sb_push("async_busy2", SEL_BUSY2, 32'd0);
    sb_drain();
    #1 RST = 1'b0;
    #1;
    sb_push("post_rst_pend", SEL_PEND, 32'd0);
    sb_push("post_rst_busy2", SEL_BUSY2, 32'd0);
    sb_drain();
    @(posedge CLK);

    // Random traffic against the reference model.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom(),
           $urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, DEPTH - 1)),
           ADDR_W'($urandom_range(0, DEPTH - 1)), ADDR_W'($urandom_range(0, DEPTH - 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised, clocked successor to the single-cycle register bank. It provides two combinational read ports with write-to-read forwarding and one synchronous write port. It also keeps a per-register pending-write scoreboard, so the pipelined datapath can detect read-after-write hazards. It sits between decode (read and reserve) and writeback (write and release) in the pipelined core.

## Interface
Parameters:
- WIDTH, 32, data width of each register
- DEPTH, 32, number of registers (power of two, ≥2)
- ADDR_W, 5, address width; must equal log2(DEPTH)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never becomes pending

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- AR1  in  ADDR_W  read address, port 1
- AR2  in  ADDR_W  read address, port 2
- DR1  out  WIDTH  read data, port 1 (combinational)
- DR2  out  WIDTH  read data, port 2 (combinational)
- BUSY1  out  1  register AR1 has an outstanding reservation (combinational)
- BUSY2  out  1  register AR2 has an outstanding reservation (combinational)
- REG_WRITE  in  1  write enable
- AW  in  ADDR_W  write address
- DIN  in  WIDTH  write data
- RESERVE  in  1  mark register ARES pending (issued producer)
- ARES  in  ADDR_W  address to reserve
- PEND_CNT  out  ADDR_W+1  number of pending registers (registered)

## Operation
- Storage: DEPTH × WIDTH registers plus a DEPTH-bit pending vector.
- Reset, asynchronous: all registers clear to 0 and all pending bits clear to 0. PEND_CNT = 0. DR1, DR2, BUSY1 and BUSY2 follow the combinational rules below.
- Write: on a CLK edge with REG_WRITE=1, mem[AW] ← DIN and pending[AW] ← 0.
  - With ZERO_REG=1 and AW=0, the write is discarded.
- Reserve: on a CLK edge with RESERVE=1, pending[ARES] ← 1.
  - With ZERO_REG=1 and ARES=0, the reserve is ignored.
- Same edge, REG_WRITE and RESERVE with AW=ARES: the data is written and pending stays 1. The new producer's reservation wins.
- Same edge, different addresses: both take effect independently.
- Read port n (n = 1, 2), priority order:
  - ZERO_REG=1 and ARn=0 → DRn=0, BUSYn=0.
  - Else REG_WRITE=1 and AW=ARn → DRn=DIN (forward), BUSYn=0. The forwarding write releases the register.
  - Else DRn=mem[ARn], BUSYn=pending[ARn].
- RESERVE does not affect same-cycle BUSYn. BUSYn reflects the reservation from the next cycle on.
- PEND_CNT: registered population count of the pending vector, updated on the same edge as the vector.
  - Range is 0..DEPTH; ADDR_W+1 bits are enough for the full case.
- Releasing a non-pending register and reserving an already-pending register are both legal no-ops on the count.
- Address widths are exact, so there is no out-of-range case.

## Timing
- Read latency 0: DRn and BUSYn are combinational from ARn, AW, DIN, REG_WRITE and state.
- Write latency 1: the value is visible through storage from the cycle after the edge, and through the forward path in the same cycle.
- Reserve latency 1: BUSYn rises the cycle after the RESERVE edge.
- Release latency: BUSYn drops in the same cycle as REG_WRITE (forward path), then stays low from storage.
- PEND_CNT latency 1 after any reserve or release edge.
- RST asserted mid-operation: state clears immediately without waiting for CLK. Writes and reserves are ignored while RST=1. Normal operation resumes on the first CLK edge after deassertion.

## Test plan
- Reset, then read: assert RST with all registers holding random data, read addresses 0..31 → DR=0, BUSY=0 and PEND_CNT=0 on every address.
- Write then read: write 0xDEADBEEF to r7, next cycle AR1=7 → DR1=0xDEADBEEF. Same cycle as the write, AR2=7 → DR2=0xDEADBEEF (forwarded).
- Zero register: ZERO_REG=1, write 0x12345678 to r0, reserve r0 → DR1=0 at AR1=0, BUSY1=0, PEND_CNT=0.
- Scoreboard: reserve r3 → next cycle BUSY1=1 at AR1=3 and PEND_CNT=1. Write 0x55 to r3 → same cycle BUSY1=0 and DR1=0x55. Next cycle PEND_CNT=0.
- Simultaneous reserve and write: reserve r9 and write 0xA5 to r9 on the same edge → next cycle DR1=0xA5, BUSY1=1, PEND_CNT=1.
- Async reset mid-stream: reserve r1..r31 (PEND_CNT=31), then pulse RST between clock edges → PEND_CNT=0 and all BUSY=0 immediately, with no edge required.
